// File: rtl/sram_row_streamer_if.sv
// Output stream of sram_row_streamer: a row pair plus end-of-walk marker
// under a valid/ready handshake.
interface sram_row_streamer_if #(
   parameter int unsigned DATA_W = 192
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data1;
   logic [DATA_W-1:0] out_data2;
   logic              out_last;

   modport master (output out_valid, out_data1, out_data2, out_last, input out_ready);
   modport slave  (input out_valid, out_data1, out_data2, out_last, output out_ready);
endinterface

// File: rtl/sram_row_streamer.sv
// Walks row pairs (r, r+1) through a dual-read-port SRAM and streams the captured
// words downstream through a small FIFO that absorbs backpressure.
module sram_row_streamer #(
   parameter int unsigned DATA_W     = 192,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     row_count,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   sram_raddr1,
   output logic [ADDR_W-1:0]   sram_raddr2,
   input  logic [DATA_W-1:0]   sram_rdata1,
   input  logic [DATA_W-1:0]   sram_rdata2,
   sram_row_streamer_if.master outBus
);
   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, stateNext;

   logic [ADDR_W:0]       countReg;
   logic [ADDR_W:0]       rowsIssued;
   logic                  inflight;
   logic                  inflightLast;

   logic [DATA_W-1:0]     fifoData1 [FIFO_DEPTH];
   logic [DATA_W-1:0]     fifoData2 [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifoLast;
   logic [PTR_W-1:0]      wrPtr;
   logic [PTR_W-1:0]      rdPtr;
   logic [CNT_W-1:0]      fifoCount;

   logic                  launch;
   logic                  issue;
   logic                  issueLast;
   logic                  push;
   logic                  pop;
   logic                  doneNext;
   logic [CNT_W:0]        occupancy;

   always_comb begin
      stateNext = state;
      launch    = 1'b0;
      issue     = 1'b0;
      issueLast = 1'b0;
      doneNext  = 1'b0;
      push      = inflight;
      pop       = outBus.out_valid && outBus.out_ready;
      // Slots already committed next cycle: stored rows plus the read in flight, less a pop.
      occupancy = (CNT_W+1)'(fifoCount) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
      unique case (state)
         IDLE: begin
            if (start) begin
               if (row_count == '0) begin
                  doneNext = 1'b1;
               end else begin
                  launch    = 1'b1;
                  issueLast = (row_count == (ADDR_W+1)'(1));
                  stateNext = issueLast ? DRAIN : RUN;
               end
            end
         end
         RUN: begin
            if ((rowsIssued < countReg) && (occupancy < (CNT_W+1)'(FIFO_DEPTH))) begin
               issue     = 1'b1;
               issueLast = ((rowsIssued + (ADDR_W+1)'(1)) == countReg);
               if (issueLast) stateNext = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && outBus.out_last) begin
               stateNext = IDLE;
               doneNext  = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= stateNext;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         done         <= 1'b0;
         sram_raddr1  <= '0;
         sram_raddr2  <= ADDR_W'(1);
         countReg     <= '0;
         rowsIssued   <= '0;
         inflight     <= 1'b0;
         inflightLast <= 1'b0;
      end else begin
         done         <= doneNext;
         inflight     <= launch || issue;
         inflightLast <= issueLast;
         if (launch) begin
            sram_raddr1 <= base_addr;
            sram_raddr2 <= base_addr + ADDR_W'(1);
            countReg    <= row_count;
            rowsIssued  <= (ADDR_W+1)'(1);
         end else if (issue) begin
            sram_raddr1 <= sram_raddr1 + ADDR_W'(1);
            sram_raddr2 <= sram_raddr2 + ADDR_W'(1);
            rowsIssued  <= rowsIssued + (ADDR_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fifoData1 <= '{default: '0};
         fifoData2 <= '{default: '0};
         fifoLast  <= '0;
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
      end else begin
         if (push) begin
            fifoData1[wrPtr] <= sram_rdata1;
            fifoData2[wrPtr] <= sram_rdata2;
            fifoLast[wrPtr]  <= inflightLast;
            wrPtr            <= wrPtr + PTR_W'(1);
         end
         if (pop) rdPtr <= rdPtr + PTR_W'(1);
         fifoCount <= fifoCount + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign outBus.out_valid = (fifoCount != '0);
   assign outBus.out_data1 = fifoData1[rdPtr];
   assign outBus.out_data2 = fifoData2[rdPtr];
   assign outBus.out_last  = outBus.out_valid && fifoLast[rdPtr];
endmodule
